// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave countdown timer.
package microwave_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; holds while disabled.
module tick_prescaler #(
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// BCD mm:ss countdown timer: keypad entry while idle, decrements once per tick while heating.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             magnetron,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_digit,
  input  logic             clear,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             finished_time,
  output logic             done_pulse
);

  state_e state_q, state_d;
  logic [BCD_W-1:0] mt_q, mo_q, st_q, so_q;
  logic [BCD_W-1:0] mt_d, mo_d, st_d, so_d;
  logic [BCD_W-1:0] dec_mt, dec_mo, dec_st, dec_so;
  logic fin_q, fin_d, done_q, done_d;
  logic time_nz, key_acc, run_en, tick, do_dec, dec_zero, enter_done;

  assign time_nz = |{mt_q, mo_q, st_q, so_q};
  assign key_acc = (state_q == ST_IDLE) && key_valid && (key_digit <= DIGIT_MAX) && !clear;

  // The prescaler also runs on the start cycle so the first decrement lands TICK_DIV cycles after start.
  assign run_en = magnetron && !clear && !key_acc &&
                  ((state_q == ST_RUN) || ((state_q == ST_IDLE) && time_nz));

  assign do_dec     = tick && time_nz;
  assign dec_zero   = ~|{dec_mt, dec_mo, dec_st, dec_so};
  assign enter_done = do_dec && dec_zero;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run_en),
    .clr  (clear || enter_done),
    .tick (tick)
  );

  // sec_tens values 6-9 from keypad entry simply count down; only a borrow reloads it to 5.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q;
    if (so_q != '0) begin
      dec_so = so_q - 1'b1;
    end else begin
      dec_so = DIGIT_MAX;
      if (st_q != '0) begin
        dec_st = st_q - 1'b1;
      end else begin
        dec_st = SEC_TENS_MAX;
        if (mo_q != '0) begin
          dec_mo = mo_q - 1'b1;
        end else begin
          dec_mo = DIGIT_MAX;
          dec_mt = mt_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      mt_d    = '0;
      mo_d    = '0;
      st_d    = '0;
      so_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (magnetron && time_nz) state_d = ST_RUN;
        ST_RUN:  if (!magnetron) state_d = ST_IDLE;
        ST_DONE: if (!magnetron) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (key_acc) begin
        mt_d = mo_q;
        mo_d = st_q;
        st_d = so_q;
        so_d = key_digit;
      end
      if (do_dec) begin
        mt_d = dec_mt;
        mo_d = dec_mo;
        st_d = dec_st;
        so_d = dec_so;
        if (dec_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end
    fin_d = ~|{mt_d, mo_d, st_d, so_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mt_q    <= '0;
      mo_q    <= '0;
      st_q    <= '0;
      so_q    <= '0;
      fin_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
    end
  end

  assign min_tens      = mt_q;
  assign min_ones      = mo_q;
  assign sec_tens      = st_q;
  assign sec_ones      = so_q;
  assign finished_time = fin_q;
  assign done_pulse    = done_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed and random stimulus for microwave_timer checked against a minutes/seconds reference model.
module tb_microwave_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       magnetron = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       clear = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       finished_time, done_pulse;

  int errs = 0;
  int checks = 0;

  // Reference model: time as whole minutes and seconds, phase as 0=idle 1=running 2=finished.
  int   m_phase = 0;
  int   m_cnt = 0;
  int   m_mins = 0;
  int   m_secs = 0;
  logic m_done = 1'b0;

  always #5 clk = ~clk;

  microwave_timer #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .magnetron    (magnetron),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .clear        (clear),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .finished_time(finished_time),
    .done_pulse   (done_pulse)
  );

  function automatic logic [15:0] bcd(input int mi, input int se);
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic model_step(input logic mag, input logic kv, input int kd, input logic clr);
    bit nz, kacc, go, dec;
    int nxt, v;
    if (clr) begin
      m_mins = 0; m_secs = 0; m_cnt = 0; m_phase = 0; m_done = 1'b0;
    end else begin
      nz   = (m_mins != 0) || (m_secs != 0);
      kacc = (m_phase == 0) && kv && (kd <= 9);
      go   = mag && !kacc && ((m_phase == 1) || ((m_phase == 0) && nz));
      dec  = 0;
      m_done = 1'b0;
      if (go) begin
        if (m_cnt == TD - 1) begin m_cnt = 0; dec = 1; end
        else m_cnt++;
      end
      nxt = m_phase;
      if (m_phase == 0 && mag && nz) nxt = 1;
      else if (m_phase != 0 && !mag) nxt = 0;
      if (kacc) begin
        v = ((m_mins * 100 + m_secs) * 10 + kd) % 10000;
        m_mins = v / 100;
        m_secs = v % 100;
      end
      if (dec) begin
        if (m_secs > 0) m_secs--;
        else begin m_mins--; m_secs = 59; end
        if (m_mins == 0 && m_secs == 0) begin nxt = 2; m_cnt = 0; m_done = 1'b1; end
      end
      m_phase = nxt;
    end
  endtask

  task automatic step(input logic mag, input logic kv, input int kd, input logic clr);
    magnetron = mag;
    key_valid = kv;
    key_digit = 4'(kd);
    clear     = clr;
    @(posedge clk);
    model_step(mag, kv, kd, clr);
    #1;
    chk("disp", disp(), bcd(m_mins, m_secs));
    chk("finished", 16'(finished_time), 16'((m_mins == 0 && m_secs == 0) ? 1 : 0));
    chk("done_pulse", 16'(done_pulse), 16'(m_done));
    key_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic key(input int d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    int pulses;
    logic mag_r;
    #12;
    chk("rst_disp", disp(), 16'h0000);
    chk("rst_finished", 16'(finished_time), 16'h0001);
    chk("rst_done", 16'(done_pulse), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("zero_start_hold", disp(), 16'h0000);
    step(1'b0, 1'b0, 0, 1'b0);

    key(1); key(3); key(0);
    chk("entry_0130", disp(), 16'h0130);
    chk("entry_fin", 16'(finished_time), 16'h0000);
    for (int i = 0; i < TD; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("first_dec_0129", disp(), 16'h0129);
    for (int i = 0; i < 30 * TD; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("borrow_0059", disp(), 16'h0059);

    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    key(0); key(5);
    chk("entry_0005", disp(), 16'h0005);
    pulses = 0;
    for (int i = 0; i < 5 * TD; i++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      if (done_pulse) pulses++;
    end
    step(1'b1, 1'b0, 0, 1'b0);
    if (done_pulse) pulses++;
    chk("done_pulse_count", 16'(pulses), 16'h0001);
    chk("reach_zero", disp(), 16'h0000);
    chk("zero_fin", 16'(finished_time), 16'h0001);
    step(1'b0, 1'b0, 0, 1'b0);

    key(2); key(0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("run6_0019", disp(), 16'h0019);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 1'b0);
    chk("pause_hold_0019", disp(), 16'h0019);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("partial_kept_0018", disp(), 16'h0018);
    for (int i = 0; i < 3 * TD; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("at_0015", disp(), 16'h0015);
    step(1'b1, 1'b1, 7, 1'b0);
    chk("key_in_run_ignored", disp(), 16'h0015);
    step(1'b1, 1'b0, 0, 1'b1);
    chk("clear_disp", disp(), 16'h0000);
    chk("clear_no_done", 16'(done_pulse), 16'h0000);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    key(9); key(0);
    chk("entry_0090", disp(), 16'h0090);
    for (int i = 0; i < TD; i++) step(1'b1, 1'b0, 0, 1'b0);
    chk("dec_0089", disp(), 16'h0089);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 12, 1'b0);
    chk("bad_digit_ignored", disp(), 16'h0089);
    step(1'b0, 1'b1, 5, 1'b1);
    chk("clear_beats_key", disp(), 16'h0000);

    mag_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) mag_r = ~mag_r;
      if (mag_r)
        step(1'b1, 1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 199) == 0));
      else
        step(1'b0, 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 11)),
             1'($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
Countdown timer at the other end of the control interface. It consumes `magnetron` from `control` and produces `finished_time` back to it. Keypad digits are entered as BCD mm:ss while the magnetron is off. The time counts down once per second while `magnetron`=1. It raises `finished_time` when the count is 0:00. The block sits beside `control` in the microwave top level and drives the 4-digit display.

Parameters:
- TICK_DIV, 100, clk cycles per 1-second tick (small in simulation, board clock rate in synthesis); must be ≥2.
- CNT_W, 27, width of the prescaler counter; must hold TICK_DIV-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- magnetron  in  1  from control; 1 = heating, countdown enabled.
- key_valid  in  1  one-cycle strobe; a keypad digit is present.
- key_digit  in  4  keypad digit, BCD 0-9.
- clear  in  1  level; zeroes the time.
- min_tens  out  4  BCD display digit.
- min_ones  out  4  BCD display digit.
- sec_tens  out  4  BCD display digit.
- sec_ones  out  4  BCD display digit.
- finished_time  out  1  to control; 1 while the time is 0:00.
- done_pulse  out  1  one-cycle pulse when a countdown reaches 0:00.

Behaviour:
- Reset (rst_n=0, async):
  - All digits = 0; prescaler = 0; state = IDLE.
  - finished_time = 1 (time is 0:00); done_pulse = 0.
- States:
  - IDLE: magnetron=0.
  - RUN: magnetron=1 and time ≠ 0.
  - DONE: reached 0:00 by countdown.
  - Transitions:
    - IDLE→RUN when magnetron=1 and time≠0.
    - RUN→IDLE when magnetron falls (pause; digits hold).
    - RUN→DONE on the decrement that produces 0:00.
    - DONE→IDLE when magnetron=0 or clear=1.
    - IDLE with magnetron=1 and time=0 stays IDLE.
- Digit entry: only in IDLE.
  - On key_valid with key_digit ≤9, shift left one place, all registered in one cycle:
    - min_tens ← min_ones
    - min_ones ← sec_tens
    - sec_tens ← sec_ones
    - sec_ones ← key_digit
  - key_digit >9 is ignored.
  - key_valid in RUN or DONE is ignored.
  - A fifth digit drops the old min_tens.
  - sec_tens may hold 6-9 after entry (e.g. 00:90 = 90 s); this is legal.
- clear:
  - In any state, zeroes all digits and the prescaler next cycle.
  - Goes to IDLE.
  - Does not produce done_pulse.
  - clear beats key_valid in the same cycle.
- Prescaler (sub-module):
  - Counts 0..TICK_DIV-1 only while in RUN.
  - tick = 1 for one cycle when the count equals TICK_DIV-1, then wraps to 0.
  - Holds its value when paused, so a partial second is kept.
  - Cleared by clear or on entering DONE.
- Decrement on tick in RUN, BCD with borrow:
  - sec_ones 0→9, borrow.
  - sec_tens 0→5, borrow; values 6-9 decrement normally.
  - min_ones 0→9, borrow.
  - min_tens decrements.
  - Never decrements below 0:00.
- finished_time: registered; 1 whenever all four digits are 0, updated in the same cycle as the digits.
- done_pulse: 1 for exactly the cycle after the decrement that reaches 0:00.
- Simultaneous events:
  - tick in the same cycle magnetron falls: no decrement (state already leaves RUN).
  - tick and clear together: clear wins.
- Latency:
  - Keypad digit → display: 1 cycle.
  - Start → first decrement: TICK_DIV cycles.
- Maximum time 99:59. No saturation logic is needed because entry cannot exceed 99:99; 99:99 counts 99:99→99:98…→99:60→99:59.

Decomposition:
- Package microwave_pkg:
  - State encoding IDLE/RUN/DONE (2 bits).
  - BCD_W=4, SEC_TENS_MAX=5, DIGIT_MAX=9.
- Sub-module tick_prescaler (params TICK_DIV, CNT_W; ports clk, rst_n, en, clr, tick).
- The BCD decrement chain stays inline in microwave_timer.

Test Plan:
- Reset, then release rst_n → all digits 0, finished_time=1, done_pulse=0; magnetron=1 leaves state IDLE with no decrement.
- TICK_DIV=4; keys 1,3,0 → display 01:30, finished_time=0. magnetron=1 for 4 cycles → 01:29. Continue 120 cycles → 00:59 (borrow path 01:00→00:59).
- Keys 0,5; run 20 cycles → 00:00. done_pulse high exactly 1 cycle; finished_time=1, state DONE. magnetron=0 → IDLE.
- Keys 2,0; run 6 cycles; magnetron=0 for 10 cycles → display holds 00:19. Resume 2 cycles → 00:18 (partial second kept).
- During RUN at 00:15, key_valid with digit 7 → ignored. Then clear=1 → 00:00, finished_time=1, no done_pulse, state IDLE.
- Keys 9,0 → 00:90; run 4 cycles → 00:89. key_digit=12 with key_valid in IDLE → no change.
